tbec_decoder_apb: RTL

- APB3 slave that decodes TBEC-RSC codewords produced by the team's encoder peripheral and returns the 16-bit payload.
- Software writes a 32-bit codeword. A registered multi-cycle FSM runs the decode core and latches the data, the correction flags and saturating error statistics.
- Sits on the same APB bus as the encoder peripheral and forms the receive/check side of the encode → store/transmit → decode path.

---
 rtl/tbec_pkg.sv | 31 +++
 rtl/tbec_decoder_core.sv | 53 +++++
 rtl/tbec_decoder_apb.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/tbec_pkg.sv
// Shared constants and types for the TBEC-RSC decoder peripheral.
package tbec_pkg;

    localparam int DATA_W = 16;
    localparam int CODE_W = 32;

    localparam logic [1:0] REG_CODE   = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_COUNT  = 2'd3;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_CORR = 2;
    localparam int STAT_UNC  = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        DECODE = 1'b1
    } state_t;

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tbec_decoder_core.sv
// Combinational TBEC-RSC check: data is a 4x4 grid, [19:16] row parity,
// [23:20] column parity, [31:24] reserved zero. Corrects any single-bit error.
module tbec_decoder_core
    import tbec_pkg::*;
(
    input  logic [CODE_W-1:0] codeword,
    output logic [DATA_W-1:0] data16,
    output logic              corrected,
    output logic              uncorr
);

    logic [3:0]        row_syn;
    logic [3:0]        col_syn;
    logic [7:0]        rsv_syn;
    logic [3:0]        row_n;
    logic [3:0]        col_n;
    logic [3:0]        rsv_n;
    logic [4:0]        tot_n;
    logic              single_data;
    logic              single_chk;
    logic [DATA_W-1:0] flip_mask;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_syn
            assign row_syn[gi] = (^codeword[4*gi +: 4]) ^ codeword[16+gi];
            assign col_syn[gi] = codeword[gi] ^ codeword[gi+4] ^ codeword[gi+8]
                               ^ codeword[gi+12] ^ codeword[20+gi];
        end
    endgenerate

    assign rsv_syn = codeword[31:24];
    assign row_n   = ones8({4'b0000, row_syn});
    assign col_n   = ones8({4'b0000, col_syn});
    assign rsv_n   = ones8(rsv_syn);
    assign tot_n   = {1'b0, row_n} + {1'b0, col_n} + {1'b0, rsv_n};

    // One row and one column disagreeing pinpoints a data bit; a lone
    // mismatch anywhere else is a flipped check bit and the data is intact.
    assign single_data = (row_n == 4'd1) && (col_n == 4'd1) && (rsv_n == 4'd0);
    assign single_chk  = (tot_n == 5'd1);

    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_flip
            assign flip_mask[gi] = single_data & row_syn[gi/4] & col_syn[gi%4];
        end
    endgenerate

    assign data16    = codeword[DATA_W-1:0] ^ flip_mask;
    assign corrected = single_data | single_chk;
    assign uncorr    = (tot_n != 5'd0) & ~(single_data | single_chk);

endmodule

// File: rtl/tbec_decoder_apb.sv
// APB3 slave wrapping the TBEC-RSC decode core: codeword register, decode FSM,
// result/status latches and saturating correction statistics.
module tbec_decoder_apb
    import tbec_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int DEC_CYCLES = 2
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR
);

    localparam logic [2:0] LAST_CYC = 3'(DEC_CYCLES - 1);

    state_t            state_q, state_d;
    logic [2:0]        cyc_q, cyc_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              corr_q, corr_d;
    logic              unc_q, unc_d;
    logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0]  unc_cnt_q, unc_cnt_d;

    logic [1:0]        addr;
    logic              busy;
    logic              pready;
    logic              wr_acc;
    logic              code_wr;
    logic              done_clr;
    logic              cnt_clr;
    logic [DATA_W-1:0] core_data;
    logic              core_corr;
    logic              core_unc;
    logic [15:0]       corr16;
    logic [15:0]       unc16;
    logic              unused_addr_bits;

    assign addr             = PADDR[3:2];
    assign unused_addr_bits = ^{PADDR[31:4], PADDR[1:0]};
    assign busy             = (state_q == DECODE);

    // STATUS stays accessible mid-decode so software can poll and clear DONE.
    assign pready   = ~(PSEL & busy & (addr != REG_STATUS));
    assign wr_acc   = PSEL & PENABLE & PWRITE & pready;
    assign code_wr  = wr_acc & (addr == REG_CODE);
    assign done_clr = wr_acc & (addr == REG_STATUS) & PWDATA[STAT_DONE];
    assign cnt_clr  = wr_acc & (addr == REG_COUNT);

    tbec_decoder_core u_core (
        .codeword  (code_q),
        .data16    (core_data),
        .corrected (core_corr),
        .uncorr    (core_unc)
    );

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        code_d     = code_q;
        data_d     = data_q;
        done_d     = done_q;
        corr_d     = corr_q;
        unc_d      = unc_q;
        corr_cnt_d = corr_cnt_q;
        unc_cnt_d  = unc_cnt_q;

        if (done_clr) begin
            done_d = 1'b0;
        end
        if (cnt_clr) begin
            corr_cnt_d = '0;
            unc_cnt_d  = '0;
        end

        case (state_q)
            IDLE: begin
                if (code_wr) begin
                    code_d  = PWDATA;
                    state_d = DECODE;
                    cyc_d   = '0;
                    done_d  = 1'b0;
                    corr_d  = 1'b0;
                    unc_d   = 1'b0;
                end
            end
            DECODE: begin
                if (cyc_q == LAST_CYC) begin
                    state_d = IDLE;
                    data_d  = core_data;
                    corr_d  = core_corr;
                    unc_d   = core_unc;
                    done_d  = 1'b1;
                    if (core_corr && !core_unc && (corr_cnt_q != '1)) begin
                        corr_cnt_d = corr_cnt_q + CNT_W'(1);
                    end
                    if (core_unc && (unc_cnt_q != '1)) begin
                        unc_cnt_d = unc_cnt_q + CNT_W'(1);
                    end
                end else begin
                    cyc_d = cyc_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q    <= IDLE;
            cyc_q      <= '0;
            code_q     <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            corr_q     <= 1'b0;
            unc_q      <= 1'b0;
            corr_cnt_q <= '0;
            unc_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            code_q     <= code_d;
            data_q     <= data_d;
            done_q     <= done_d;
            corr_q     <= corr_d;
            unc_q      <= unc_d;
            corr_cnt_q <= corr_cnt_d;
            unc_cnt_q  <= unc_cnt_d;
        end
    end

    generate
        if (CNT_W >= 16) begin : g_cnt_trunc
            assign corr16 = corr_cnt_q[15:0];
            assign unc16  = unc_cnt_q[15:0];
        end else begin : g_cnt_ext
            assign corr16 = {{(16-CNT_W){1'b0}}, corr_cnt_q};
            assign unc16  = {{(16-CNT_W){1'b0}}, unc_cnt_q};
        end
    endgenerate

    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE) begin
            case (addr)
                REG_CODE:   PRDATA = code_q;
                REG_DATA:   PRDATA = {16'h0000, data_q};
                REG_STATUS: PRDATA = {28'h0, unc_q, corr_q, done_q, busy};
                REG_COUNT:  PRDATA = {unc16, corr16};
                default:    PRDATA = '0;
            endcase
        end
    end

    assign PREADY  = pready;
    assign PSLVERR = 1'b0;

endmodule
